mul_ko_param: RTL and testbench
===============================

# mul_ko_param

Parametrised one-level Karatsuba multiplier producing the full `2*WIDTH`-bit product of two `WIDTH`-bit unsigned operands. It has a valid/ready/finish handshake and an additional squaring mode. Three half-width sub-products are issued back-to-back into a single pipelined sub-multiplier, then combined. It sits under the SM2 modular-multiplication datapath, ahead of reduction, and serves 256-bit field operands by default.

## Interface
- `WIDTH`, 256: operand width. Must be even and ≥ 8. `HALF = WIDTH/2`.
- `MUL_LAT`, 2: pipeline latency of the sub-multiplier in cycles. Must be ≥ 1.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mul_vld_i` in 1: request; sampled only while `mul_rdy_o` is 1.
- `mul_sqr_i` in 1: squaring mode, sampled with the request. When set, `mul_b_i` is ignored and the result is `a*a`.
- `mul_a_i` in WIDTH: operand A, latched at acceptance.
- `mul_b_i` in WIDTH: operand B, latched at acceptance.
- `mul_rdy_o` out 1: block is idle and can accept a request.
- `mul_fin_o` out 1: one-cycle pulse indicating `mul_r_o` holds a new result.
- `mul_r_o` out 2*WIDTH: product. Held stable until the next `mul_fin_o`.

## Operation
- **Reset values:** `mul_rdy_o`=1, `mul_fin_o`=0, `mul_r_o`=0, state IDLE. The sub-multiplier valid tags are cleared.
- **Acceptance:** a request is accepted at a rising edge where `mul_vld_i & mul_rdy_o`. At that edge A, B and the sqr flag are latched, and the state moves to ISSUE. `mul_vld_i` while busy is ignored; there is no queuing.
- **Operand split:** `aL = a[HALF-1:0]`, `aH = a[WIDTH-1:HALF]`; B is split the same way.
- **ISSUE** (3 cycles, 2-bit counter 0..2). One product is issued per cycle:
  - `P0 = aL*bL`
  - `P2 = aH*bH`
  - `P1 = (aL+aH)*(bL+bH)`, with the sums HALF+1 bits wide.
  - In sqr mode: `P0 = aL*aL`, `P2 = aH*aH`, `P1 = aL*aH`.
- **WAIT:** collects the returning products into P0/P1/P2 registers, keyed by a 2-bit tag carried through the pipe. The state leaves WAIT the cycle after the P1 tag returns.
- **COMB** (1 cycle): `r = (P2 << WIDTH) + (M << HALF) + P0`.
  - Normal mode: `M = P1 - P2 - P0`.
  - Sqr mode: `M = P1 << 1`.
  - M is computed in WIDTH+2 bits and is never negative. The final sum is truncated to 2*WIDTH bits, which is exact.
  - The state then returns to IDLE. `mul_r_o` is loaded and `mul_fin_o` is asserted for that one cycle.
- **State flow:** IDLE → ISSUE → WAIT → COMB → IDLE.
- **Boundary cases:**
  - All-ones operands: P1 uses the full HALF+1-bit sums with no truncation.
  - Zero operands produce a normal finish.
  - Reset mid-operation: the next cycle is IDLE with outputs at reset values. In-flight products are dropped by tag clear, and no spurious `mul_fin_o` is produced.

## Timing
- **Latency:** `mul_fin_o` is high in cycle `MUL_LAT+4` after the accepting edge. With defaults this is 6.
- **Ready during the finish cycle:** `mul_rdy_o` is 1 in the `mul_fin_o` cycle, so a request there is accepted immediately.
- **Throughput:** with `mul_vld_i` held high, one result every `MUL_LAT+5` cycles (7 with defaults).
- **Busy window:** `mul_rdy_o` is 0 from the cycle after acceptance through the COMB cycle.

## Configuration
- **`MUL_KO_REG_OUT_EN` defined:** an extra output register stage is inserted.
  - `mul_r_o` and `mul_fin_o` are delayed by one cycle, so latency is `MUL_LAT+5`.
  - `mul_rdy_o` still rises with the COMB→IDLE transition, so throughput is unchanged.
  - This helps timing closure into reduction.
- **Undefined:** behaviour is as described above.

## Structure
- **Shared package `mul_ko_pkg`:**
  - State enum: IDLE, ISSUE, WAIT, COMB.
  - Tag constants: `TAG_P0=0`, `TAG_P2=1`, `TAG_P1=2`.
  - Function `half_of(WIDTH)`.
- **Sub-module `mul_ko_sub`:** `(HALF+1)x(HALF+1)` unsigned multiplier.
  - `MUL_LAT`-stage pipeline with valid and 2-bit tag passed alongside.
  - Reset clears all valids.

## Test plan
- **Unit product:** WIDTH=256, a=1, b=1 → `mul_fin_o` in cycle 6 after acceptance, `mul_r_o`=1; `mul_rdy_o` low during cycles 1–5.
- **Max operands:** a=b=2^256−1 → `mul_r_o` = 2^512 − 2^257 + 1. This exercises the carry out of the HALF+1-bit sums.
- **Squaring:** `mul_sqr_i`=1, a = 2^128+3, b = 0xDEAD (ignored) → `mul_r_o` = 2^256 + 6·2^128 + 9.
- **Back-to-back:** `mul_vld_i` held high for 10 random pairs → 10 fin pulses spaced exactly 7 cycles apart, each equal to `a*b`. A request asserted mid-operation is not accepted.
- **Reset mid-operation:** `rst` pulsed in cycle 3 of an operation → no `mul_fin_o`, `mul_r_o`=0, `mul_rdy_o`=1 the next cycle. A following a=3, b=5 request returns 15 in cycle 6.
- **Random regression:** WIDTH=64/MUL_LAT=1 and WIDTH=256/MUL_LAT=3, 10k random normal and sqr requests each, compared against the `a*b` reference. Rerun with `MUL_KO_REG_OUT_EN` defined: latency +1, results identical.

Source files
------------

// File: rtl/mul_ko_pkg.sv
// Shared types and constants for the one-level Karatsuba multiplier.
package mul_ko_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    COMB  = 2'd3
  } ko_state_e;

  typedef logic [1:0] ko_tag_t;

  localparam ko_tag_t TAG_P0 = 2'd0;
  localparam ko_tag_t TAG_P2 = 2'd1;
  localparam ko_tag_t TAG_P1 = 2'd2;

  function automatic int half_of(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/mul_ko_sub.sv
// Pipelined (OW x OW) unsigned sub-multiplier; a valid bit and a 2-bit tag
// travel alongside each product through MUL_LAT register stages.
module mul_ko_sub
  import mul_ko_pkg::*;
#(
  parameter int OW      = 129,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld_i,
  input  ko_tag_t         in_tag_i,
  input  logic [OW-1:0]   in_x_i,
  input  logic [OW-1:0]   in_y_i,
  output logic            out_vld_o,
  output ko_tag_t         out_tag_o,
  output logic [2*OW-1:0] out_p_o
);

  logic [MUL_LAT-1:0] vld_q;
  ko_tag_t            tag_q  [MUL_LAT];
  logic [2*OW-1:0]    prod_q [MUL_LAT];

  // Valid shift chain; reset drops every in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Product and tag pipeline; payload is qualified by the valid chain.
  always_ff @(posedge clk) begin
    tag_q[0]  <= in_tag_i;
    prod_q[0] <= {{OW{1'b0}}, in_x_i} * {{OW{1'b0}}, in_y_i};
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_q[i]  <= tag_q[i-1];
      prod_q[i] <= prod_q[i-1];
    end
  end

  assign out_vld_o = vld_q[MUL_LAT-1];
  assign out_tag_o = tag_q[MUL_LAT-1];
  assign out_p_o   = prod_q[MUL_LAT-1];

endmodule

// File: rtl/mul_ko_param.sv
// One-level Karatsuba multiplier with valid/ready/finish handshake and squaring mode.
// Define MUL_KO_REG_OUT_EN to add one output register stage on mul_r_o/mul_fin_o.
module mul_ko_param
  import mul_ko_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mul_vld_i,
  input  logic               mul_sqr_i,
  input  logic [WIDTH-1:0]   mul_a_i,
  input  logic [WIDTH-1:0]   mul_b_i,
  output logic               mul_rdy_o,
  output logic               mul_fin_o,
  output logic [2*WIDTH-1:0] mul_r_o
);

  localparam int HALF = half_of(WIDTH);
  localparam int SW   = HALF + 1;
  localparam int PW   = 2 * SW;

  ko_state_e          state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sqr_q, sqr_d;
  logic [PW-1:0]      p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [2*WIDTH-1:0] r_q, r_d;
  logic               fin_q, fin_d;
  logic               rdy_q, rdy_d;

  logic [SW-1:0]      a_lo_s, a_hi_s, b_lo_s, b_hi_s, a_sum_s, b_sum_s;
  logic               iss_vld_s;
  ko_tag_t            iss_tag_s;
  logic [SW-1:0]      iss_x_s, iss_y_s;
  logic               ret_vld_s;
  ko_tag_t            ret_tag_s;
  logic [PW-1:0]      ret_p_s;
  logic [PW-1:0]      m_s;
  logic [2*WIDTH-1:0] r_sum_s;

  assign a_lo_s  = {1'b0, a_q[HALF-1:0]};
  assign a_hi_s  = {1'b0, a_q[WIDTH-1:HALF]};
  assign b_lo_s  = {1'b0, b_q[HALF-1:0]};
  assign b_hi_s  = {1'b0, b_q[WIDTH-1:HALF]};
  // Sums keep the carry bit so all-ones halves are not truncated.
  assign a_sum_s = a_lo_s + a_hi_s;
  assign b_sum_s = b_lo_s + b_hi_s;

  // Issue mux: one half-width product per ISSUE cycle, in P0, P2, P1 order.
  always_comb begin
    iss_vld_s = 1'b0;
    iss_tag_s = TAG_P0;
    iss_x_s   = '0;
    iss_y_s   = '0;
    if (state_q == ISSUE) begin
      iss_vld_s = 1'b1;
      case (cnt_q)
        2'd0: begin
          iss_tag_s = TAG_P0;
          iss_x_s   = a_lo_s;
          iss_y_s   = sqr_q ? a_lo_s : b_lo_s;
        end
        2'd1: begin
          iss_tag_s = TAG_P2;
          iss_x_s   = a_hi_s;
          iss_y_s   = sqr_q ? a_hi_s : b_hi_s;
        end
        2'd2: begin
          iss_tag_s = TAG_P1;
          iss_x_s   = sqr_q ? a_lo_s : a_sum_s;
          iss_y_s   = sqr_q ? a_hi_s : b_sum_s;
        end
        default: begin
          iss_vld_s = 1'b0;
        end
      endcase
    end else begin
      iss_vld_s = 1'b0;
    end
  end

  mul_ko_sub #(
    .OW      (SW),
    .MUL_LAT (MUL_LAT)
  ) u_sub (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (iss_vld_s),
    .in_tag_i  (iss_tag_s),
    .in_x_i    (iss_x_s),
    .in_y_i    (iss_y_s),
    .out_vld_o (ret_vld_s),
    .out_tag_o (ret_tag_s),
    .out_p_o   (ret_p_s)
  );

  // Recombination: the middle term is the cross sum, non-negative by construction.
  always_comb begin
    m_s     = '0;
    r_sum_s = '0;
    if (sqr_q) begin
      m_s = {p1_q[PW-2:0], 1'b0};
    end else begin
      m_s = p1_q - p2_q - p0_q;
    end
    r_sum_s = {p2_q[WIDTH-1:0], {WIDTH{1'b0}}}
            + ({{(2*WIDTH-PW){1'b0}}, m_s} << HALF)
            + {{WIDTH{1'b0}}, p0_q[WIDTH-1:0]};
  end

  // Next-state logic for the IDLE/ISSUE/WAIT/COMB sequence and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sqr_d   = sqr_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    r_d     = r_q;
    fin_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_vld_i) begin
          a_d     = mul_a_i;
          b_d     = mul_b_i;
          sqr_d   = mul_sqr_i;
          cnt_d   = 2'd0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q == 2'd2) begin
          cnt_d   = 2'd0;
          state_d = WAIT;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      WAIT: begin
        if (ret_vld_s && (ret_tag_s == TAG_P1)) begin
          state_d = COMB;
        end else begin
          state_d = WAIT;
        end
      end
      COMB: begin
        r_d     = r_sum_s;
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ret_vld_s) begin
      case (ret_tag_s)
        TAG_P0:  p0_d = ret_p_s;
        TAG_P2:  p2_d = ret_p_s;
        TAG_P1:  p1_d = ret_p_s;
        default: p0_d = p0_q;
      endcase
    end else begin
      p0_d = p0_q;
    end
    rdy_d = (state_d == IDLE);
  end

  // State, operand, partial-product and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      sqr_q   <= 1'b0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      r_q     <= '0;
      fin_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sqr_q   <= sqr_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      r_q     <= r_d;
      fin_q   <= fin_d;
      rdy_q   <= rdy_d;
    end
  end

  assign mul_rdy_o = rdy_q;

`ifdef MUL_KO_REG_OUT_EN
  logic [2*WIDTH-1:0] r_out_q;
  logic               fin_out_q;

  // Extra output stage; ready is not delayed so throughput is unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q   <= '0;
      fin_out_q <= 1'b0;
    end else begin
      r_out_q   <= r_q;
      fin_out_q <= fin_q;
    end
  end

  assign mul_r_o   = r_out_q;
  assign mul_fin_o = fin_out_q;
`else
  assign mul_r_o   = r_q;
  assign mul_fin_o = fin_q;
`endif

endmodule

// File: tb/tb_mul_ko_param.sv
// Self-checking bench for mul_ko_param: directed corner cases, back-to-back,
// reset mid-operation and randomized requests against a plain a*b reference.
module tb_mul_ko_param;

  localparam int W      = 256;
  localparam int RW     = 2 * W;
  localparam int PERIOD = 7;
`ifdef MUL_KO_REG_OUT_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic          sqr;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          rdy;
  logic          fin;
  logic [RW-1:0] r;

  int total = 0;
  int bad   = 0;

  mul_ko_param #(
    .WIDTH   (W),
    .MUL_LAT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mul_vld_i (vld),
    .mul_sqr_i (sqr),
    .mul_a_i   (a),
    .mul_b_i   (b),
    .mul_rdy_o (rdy),
    .mul_fin_o (fin),
    .mul_r_o   (r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    logic [RW-1:0] xe;
    logic [RW-1:0] ye;
    xe = {{W{1'b0}}, x};
    ye = s ? xe : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) begin
      v[i*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  // Each half independently random, all-ones or zero.
  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = rand_w();
    for (int h = 0; h < 2; h++) begin
      case ($urandom_range(0, 3))
        0:       v[h*(W/2) +: W/2] = '1;
        1:       v[h*(W/2) +: W/2] = '0;
        default: v[h*(W/2) +: W/2] = v[h*(W/2) +: W/2];
      endcase
    end
    return v;
  endfunction

  task automatic wait_rdy(input string tg);
    int n;
    n = 0;
    while (!rdy && n < 20) begin
      step();
      n++;
    end
    chk({tg, "_rdy_wait"}, RW'(rdy), RW'(1'b1));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input string tg, input bit chk_rdy);
    logic [RW-1:0] e;
    e = ref_mul(x, y, s);
    wait_rdy(tg);
    a   = x;
    b   = y;
    sqr = s;
    vld = 1'b1;
    step();
    vld = 1'b0;
    a   = rand_w();
    b   = rand_w();
    sqr = 1'($urandom_range(0, 1));
    for (int c = 0; c < LAT; c++) begin
      chk({tg, "_fin_early"}, RW'(fin), RW'(1'b0));
      if (chk_rdy) begin
        chk({tg, "_rdy_busy"}, RW'(rdy), RW'((c <= 5) ? 1'b0 : 1'b1));
      end
      step();
    end
    chk({tg, "_fin"}, RW'(fin), RW'(1'b1));
    chk({tg, "_r"}, r, e);
    if (chk_rdy) begin
      chk({tg, "_rdy_fin"}, RW'(rdy), RW'(1'b1));
    end
    step();
    chk({tg, "_fin_pulse"}, RW'(fin), RW'(1'b0));
    chk({tg, "_r_hold"}, r, e);
  endtask

  task automatic back_to_back();
    logic [W-1:0]  xa [10];
    logic [W-1:0]  xb [10];
    logic [RW-1:0] e  [10];
    bit            exp_fin;
    int            k;
    for (int i = 0; i < 10; i++) begin
      xa[i] = rand_w();
      xb[i] = rand_w();
      e[i]  = ref_mul(xa[i], xb[i], 1'b0);
    end
    wait_rdy("b2b");
    a   = xa[0];
    b   = xb[0];
    sqr = 1'b0;
    vld = 1'b1;
    for (int n = 0; n < 9 * PERIOD + LAT + 3; n++) begin
      step();
      if (n % PERIOD == 0) begin
        k = n / PERIOD + 1;
        if (k < 10) begin
          a = xa[k];
          b = xb[k];
        end else begin
          vld = 1'b0;
        end
      end
      exp_fin = (n >= LAT) && ((n - LAT) % PERIOD == 0) && ((n - LAT) / PERIOD < 10);
      chk("b2b_fin", RW'(fin), RW'(exp_fin));
      if (exp_fin) begin
        chk("b2b_r", r, e[(n - LAT) / PERIOD]);
      end
    end
  endtask

  task automatic reset_mid_op();
    wait_rdy("rmid");
    a   = rand_w();
    b   = rand_w();
    sqr = 1'b0;
    vld = 1'b1;
    step();
    vld = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_fin", RW'(fin), RW'(1'b0));
    chk("rmid_r", r, '0);
    chk("rmid_rdy", RW'(rdy), RW'(1'b1));
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rmid_no_fin", RW'(fin), RW'(1'b0));
    end
    run_op(256'd3, 256'd5, 1'b0, "after_rst", 1'b1);
  endtask

  initial begin
    logic [W-1:0] x;
    rst = 1'b1;
    vld = 1'b0;
    sqr = 1'b0;
    a   = '0;
    b   = '0;
    step();
    step();
    chk("reset_rdy", RW'(rdy), RW'(1'b1));
    chk("reset_fin", RW'(fin), RW'(1'b0));
    chk("reset_r", r, '0);
    rst = 1'b0;
    step();

    run_op(256'd1, 256'd1, 1'b0, "unit", 1'b1);
    run_op('1, '1, 1'b0, "max", 1'b1);
    x      = '0;
    x[128] = 1'b1;
    x[1:0] = 2'b11;
    run_op(x, 256'hDEAD, 1'b1, "sqr", 1'b1);
    run_op('0, '0, 1'b0, "zero", 1'b0);
    run_op('1, '1, 1'b1, "sqr_max", 1'b0);

    back_to_back();
    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      run_op(rand_op(), rand_op(), 1'($urandom_range(0, 1)), "rand", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
